embcpu8k_nios2_qsys_0_oci_dct_packer: RTL

//  Upstream of the OCI trace test bench: packs 2-bit branch trace atoms into
//  the 30-bit DCT buffer, counts them, closes frames on full/flush/test end.

---
 rtl/embcpu8k_oci_trace_pkg.sv | 31 +++
 rtl/embcpu8k_nios2_qsys_0_oci_dct_hold.sv | 43 ++++
 rtl/embcpu8k_nios2_qsys_0_oci_dct_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/embcpu8k_oci_trace_pkg.sv
// Shared definitions for the OCI trace path: atom codes, frame layout and
// the DCT packer state encoding.
package embcpu8k_oci_trace_pkg;

  localparam int ATOM_W    = 2;
  localparam int MAX_ATOMS = 15;
  localparam int BUF_W     = ATOM_W * MAX_ATOMS;
  localparam int CNT_W     = 4;
  localparam int DROP_W    = 8;
  localparam int FRAME_W   = CNT_W + BUF_W;

  typedef enum logic [ATOM_W-1:0] {
    ATOM_NONE   = 2'b00,
    ATOM_TAKEN  = 2'b01,
    ATOM_NTAKEN = 2'b10,
    ATOM_EXC    = 2'b11
  } atom_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PEND  = 2'd2
  } pack_state_e;

  // A closed frame as it travels to the trace FIFO: count on top, atoms below.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } frame_t;

endpackage

// File: rtl/embcpu8k_nios2_qsys_0_oci_dct_hold.sv
// One-entry valid/ready output register for closed DCT frames. Data is held
// stable while the downstream FIFO stalls; a new frame may load on the same
// edge the old one is accepted.
module embcpu8k_nios2_qsys_0_oci_dct_hold
  import embcpu8k_oci_trace_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_i,
  input  frame_t data_i,
  input  logic   ready_i,
  output logic   valid_o,
  output frame_t data_o,
  output logic   free_o
);

  logic   valid_q;
  frame_t data_q;

  // The slot can take a frame when empty or when its occupant leaves this edge.
  assign free_o = !valid_q || ready_i;

  // Load a new frame, or drop the valid flag once the current one is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too so the exported frame reads 0
      // after reset; it is a single word, not a RAM, so this costs nothing.
      data_q  <= '0;
    end else if (load_i) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of process ordering.
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/embcpu8k_nios2_qsys_0_oci_dct_packer.sv
// DCT packer: shifts 2-bit branch trace atoms into a 30-bit buffer, closes
// frames on full / flush / test end and hands them to the output register.
// While a closed frame waits for the output register (PEND) the accumulator
// is frozen and incoming atoms are counted as drops.
module embcpu8k_nios2_qsys_0_oci_dct_packer
  import embcpu8k_oci_trace_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               atom_valid,
  input  logic [ATOM_W-1:0]  atom,
  input  logic               flush_req,
  input  logic               test_ending,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_data,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  input  logic               ovf_clear
);

  pack_state_e       state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              atom_ok;
  logic              close_req;
  logic [BUF_W-1:0]  app_buf;
  logic [CNT_W-1:0]  app_cnt;
  logic              frame_close;
  logic              hold_free;
  logic              hold_load;
  logic              drop;
  frame_t            frame_d;
  frame_t            hold_data;

  // Code 00 is a bubble: neither appended nor counted as a drop.
  assign atom_ok   = atom_valid && (atom != ATOM_NONE);
  assign close_req = flush_req || test_ending;

  // Post-append view of the accumulator; a same-cycle flush sees the new atom.
  assign app_buf = atom_ok ? {buf_q[BUF_W-ATOM_W-1:0], atom} : buf_q;
  assign app_cnt = cnt_q + CNT_W'(atom_ok);

  assign frame_close = (state_q != ST_PEND) &&
                       ((app_cnt == CNT_W'(MAX_ATOMS)) ||
                        (close_req && (app_cnt != '0)));

  // State register together with the accumulator and drop bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: close hands off when the output slot is free, else parks in PEND.
  always_comb begin
    // NOTE: defaults first in every combinational block so no path leaves a
    // variable unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (frame_close) begin
          state_d = hold_free ? ST_IDLE : ST_PEND;
        end else if (atom_ok) begin
          state_d = ST_ACCUM;
        end
      end
      ST_PEND: begin
        if (hold_free) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs of the FSM: accumulator update, frame handoff and drop strobe.
  always_comb begin
    hold_load = 1'b0;
    drop      = 1'b0;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    frame_d   = '{count: cnt_q, buffer: buf_q};
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (frame_close) begin
          frame_d = '{count: app_cnt, buffer: app_buf};
          if (hold_free) begin
            hold_load = 1'b1;
            buf_d     = '0;
            cnt_d     = '0;
          end else begin
            buf_d = app_buf;
            cnt_d = app_cnt;
          end
        end else begin
          buf_d = app_buf;
          cnt_d = app_cnt;
        end
      end
      ST_PEND: begin
        drop = atom_ok;
        if (hold_free) begin
          hold_load = 1'b1;
          buf_d     = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        buf_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Sticky overflow and saturating drop counter; a clear beats a same-cycle drop.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ovf_clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  embcpu8k_nios2_qsys_0_oci_dct_hold u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (hold_load),
    .data_i  (frame_d),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (hold_data),
    .free_o  (hold_free)
  );

  assign out_data   = hold_data;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
